// File: rtl/weight_loader.sv
// Streams one filter's weights from the weight buffer into NUM_PE weight registers.
// Clears the bank first, then writes each register through a fixed 2-cycle read pipeline.
module weight_loader #(
  parameter int F_WIDTH    = 8,
  parameter int NUM_PE     = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic        [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                         hold_i,
  output logic                         mem_rd_en_o,
  output logic        [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic signed [F_WIDTH-1:0]    mem_data_i,
  output logic signed [F_WIDTH-1:0]    f_weight_o,
  output logic        [NUM_PE-1:0]     wreg_wr_en_o,
  output logic                         wreg_rst_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int IDX_W = $clog2(NUM_PE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [IDX_W-1:0]      r_issue_idx;
  logic [IDX_W-1:0]      r_pipe_idx;
  logic                  r_pipe_vld;
  logic [NUM_PE-1:0]     w_onehot;
  logic                  w_last_read;
  logic                  w_last_write;

  always_comb begin
    w_onehot             = '0;
    w_onehot[r_pipe_idx] = 1'b1;
  end

  assign w_last_read  = (r_rd_idx == IDX_W'(NUM_PE - 1));
  assign w_last_write = r_pipe_vld && (r_pipe_idx == IDX_W'(NUM_PE - 1));

  // The state leads its registered outputs by one cycle; the write pipeline runs regardless of state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_rd_idx     <= '0;
      r_issue_idx  <= '0;
      r_pipe_idx   <= '0;
      r_pipe_vld   <= 1'b0;
      mem_rd_en_o  <= 1'b0;
      mem_addr_o   <= '0;
      f_weight_o   <= '0;
      wreg_wr_en_o <= '0;
      wreg_rst_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      mem_rd_en_o  <= 1'b0;
      wreg_rst_o   <= 1'b0;
      done_o       <= 1'b0;

      r_pipe_vld   <= mem_rd_en_o;
      r_pipe_idx   <= r_issue_idx;
      wreg_wr_en_o <= r_pipe_vld ? w_onehot : '0;
      if (r_pipe_vld) begin
        f_weight_o <= mem_data_i;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_base   <= base_addr_i;
            r_rd_idx <= '0;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          wreg_rst_o <= 1'b1;
          busy_o     <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_FETCH: begin
          if (!hold_i) begin
            mem_rd_en_o <= 1'b1;
            mem_addr_o  <= r_base + ADDR_WIDTH'(r_rd_idx);
            r_issue_idx <= r_rd_idx;
            r_rd_idx    <= r_rd_idx + IDX_W'(1);
            if (w_last_read) begin
              r_state <= S_DRAIN;
            end
          end
        end
        // Wait for the final in-flight read to reach the weight bus.
        S_DRAIN: begin
          if (w_last_write) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader (NUM_PE=4): basic, hold, wrap, busy starts, mid-load reset, back-to-back.
// A buffer model returns data one cycle after each read; a register-bank model captures the writes.
module tb_weight_loader;

  localparam int FW = 8;
  localparam int NP = 4;
  localparam int AW = 10;

  typedef logic signed [FW-1:0] wvec_t [NP];

  logic                 clk = 1'b0;
  logic                 rstN = 1'b0;
  logic                 startIn = 1'b0;
  logic        [AW-1:0] baseAddr = '0;
  logic                 holdIn = 1'b0;
  logic                 memRdEn;
  logic        [AW-1:0] memAddr;
  logic signed [FW-1:0] memData = '0;
  logic signed [FW-1:0] fWeight;
  logic        [NP-1:0] wrEn;
  logic                 wregRst;
  logic                 busy;
  logic                 done;

  logic signed [FW-1:0] mem  [1024];
  logic signed [FW-1:0] bank [NP];

  int vectors = 0;
  int errors  = 0;

  weight_loader #(.F_WIDTH(FW), .NUM_PE(NP), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .start_i     (startIn),
    .base_addr_i (baseAddr),
    .hold_i      (holdIn),
    .mem_rd_en_o (memRdEn),
    .mem_addr_o  (memAddr),
    .mem_data_i  (memData),
    .f_weight_o  (fWeight),
    .wreg_wr_en_o(wrEn),
    .wreg_rst_o  (wregRst),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memRdEn) memData <= mem[memAddr];
  end

  // Weight register bank as the PE column would see it.
  always @(posedge clk) begin
    if (wregRst) begin
      for (int k = 0; k < NP; k++) bank[k] <= '0;
    end else begin
      for (int k = 0; k < NP; k++) if (wrEn[k]) bank[k] <= fWeight;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rd_en"},  32'(memRdEn), 32'd0);
    checkOutput({tag, " addr"},   32'(memAddr), 32'd0);
    checkOutput({tag, " weight"}, 32'(fWeight), 32'd0);
    checkOutput({tag, " wr_en"},  32'(wrEn),    32'd0);
    checkOutput({tag, " wrst"},   32'(wregRst), 32'd0);
    checkOutput({tag, " busy"},   32'(busy),    32'd0);
    checkOutput({tag, " done"},   32'(done),    32'd0);
  endtask

  // One full load: start at cycle 0, hold over input cycles [holdAt, holdAt+holdLen),
  // optional ignored start pulses at cycle 3 and at the done cycle.
  task automatic applyStimulus(input string name, input logic [AW-1:0] base, input int holdAt,
                               input int holdLen, input bit busyStarts, input wvec_t w);
    int rdCyc [NP];
    int c;
    int doneCyc;
    bit expRd;
    logic [AW-1:0] expAddr;
    logic [NP-1:0] expWr;
    logic signed [FW-1:0] expW;

    c = 2;
    for (int k = 0; k < NP; k++) begin
      while (c >= holdAt && c < holdAt + holdLen) c++;
      rdCyc[k] = c;
      c++;
    end
    doneCyc = rdCyc[NP-1] + 3;

    startIn  = 1'b1;
    baseAddr = base;
    tick();
    startIn  = 1'b0;
    baseAddr = ~base;

    for (int cy = 1; cy <= doneCyc; cy++) begin
      holdIn  = (cy >= holdAt && cy < holdAt + holdLen);
      startIn = busyStarts && (cy == 3 || cy == doneCyc);
      tick();
      expRd = 1'b0; expAddr = '0; expWr = '0; expW = '0;
      for (int k = 0; k < NP; k++) begin
        if (rdCyc[k] == cy) begin
          expRd = 1'b1;
          expAddr = base + AW'(k);
        end
        if (rdCyc[k] + 2 == cy) begin
          expWr = NP'(1) << k;
          expW = w[k];
        end
      end
      checkOutput($sformatf("%s c%0d rd_en", name, cy), 32'(memRdEn), 32'(expRd));
      if (expRd) checkOutput($sformatf("%s c%0d addr", name, cy), 32'(memAddr), 32'(expAddr));
      checkOutput($sformatf("%s c%0d wr_en", name, cy), 32'(wrEn), 32'(expWr));
      if (expWr != '0) checkOutput($sformatf("%s c%0d weight", name, cy), 32'(fWeight), 32'(expW));
      checkOutput($sformatf("%s c%0d wrst", name, cy), 32'(wregRst), 32'(cy == 1));
      checkOutput($sformatf("%s c%0d busy", name, cy), 32'(busy), 32'(cy < doneCyc));
      checkOutput($sformatf("%s c%0d done", name, cy), 32'(done), 32'(cy == doneCyc));
    end
    holdIn  = 1'b0;
    startIn = 1'b0;
    for (int k = 0; k < NP; k++)
      checkOutput($sformatf("%s bank%0d", name, k), 32'(bank[k]), 32'(w[k]));
  endtask

  initial begin
    wvec_t wA;
    wvec_t wB;
    wvec_t wC;
    wA = '{8'sd5, -8'sd3, 8'sd127, -8'sd128};
    wB = '{8'sd17, -8'sd1, 8'sd0, 8'sd99};
    wC = '{-8'sd1, 8'sd64, -8'sd77, 8'sd33};
    for (int i = 0; i < 1024; i++) mem[i] = 8'sh55;
    for (int k = 0; k < NP; k++) begin
      mem[10'h010 + k]       = wA[k];
      mem[(1022 + k) % 1024] = wB[k];
      mem[10'h200 + k]       = wC[k];
    end

    $display("[TB] reset");
    rstN = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    rstN = 1'b1;
    tick();

    $display("[TB] basic, hold, wrap");
    applyStimulus("basic", 10'h010, 0, 0, 1'b0, wA);
    tick();
    applyStimulus("hold", 10'h010, 3, 2, 1'b0, wA);
    applyStimulus("wrap", 10'd1022, 0, 0, 1'b0, wB);

    $display("[TB] starts while busy, then immediate restart");
    applyStimulus("busyStart", 10'h200, 0, 0, 1'b1, wC);
    applyStimulus("restart", 10'h010, 0, 0, 1'b0, wA);

    $display("[TB] reset mid-load");
    tick();
    startIn  = 1'b1;
    baseAddr = 10'h200;
    tick();
    startIn  = 1'b0;
    repeat (4) tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    tick();
    checkAllZero("midReset c6");
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("postReset %0d wr_en", i), 32'(wrEn), 32'd0);
      checkOutput($sformatf("postReset %0d done", i),  32'(done), 32'd0);
      checkOutput($sformatf("postReset %0d busy", i),  32'(busy), 32'd0);
    end
    applyStimulus("afterReset", 10'h200, 0, 0, 1'b0, wC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Streams one filter's weights from the on-chip weight buffer into a bank of `NUM_PE` weight registers. For each register it issues a buffer read, then drives the weight bus with a one-hot write enable. It first clears the whole bank with a one-cycle reset pulse, and signals completion with a done pulse. It sits between the weight buffer and the PE array, and is the write-side master for every weight register in a PE column.

## Interface
Parameters:
- `F_WIDTH`, 8, weight width in bits (signed).
- `NUM_PE`, 16, number of weight registers driven; ≥ 2.
- `ADDR_WIDTH`, 10, weight buffer address width.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_n_i`  in  1  synchronous reset, active-low.
- `start_i`  in  1  load request; sampled only in IDLE.
- `base_addr_i`  in  ADDR_WIDTH  buffer address of weight 0; latched with `start_i`.
- `hold_i`  in  1  stalls new reads while high.
- `mem_rd_en_o`  out  1  buffer read strobe.
- `mem_addr_o`  out  ADDR_WIDTH  buffer read address.
- `mem_data_i`  in  F_WIDTH  signed read data, valid exactly 1 cycle after `mem_rd_en_o`.
- `f_weight_o`  out  F_WIDTH  signed weight bus to all registers.
- `wreg_wr_en_o`  out  NUM_PE  one-hot write enable; bit k targets register k.
- `wreg_rst_o`  out  1  active-high clear pulse to all weight registers.
- `busy_o`  out  1  high from CLEAR through the last write.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- All outputs are registered. On reset, every output is 0 and the FSM is in IDLE.
- FSM states: IDLE → CLEAR → FETCH → DRAIN → DONE → IDLE.
- IDLE:
  - `start_i`=1 latches `base_addr_i` and clears the read index `rd_idx` to 0.
  - Next state is CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle with `wreg_rst_o`=1.
  - Next state is FETCH.
- FETCH:
  - Each cycle with `hold_i`=0: `mem_rd_en_o`=1, `mem_addr_o`=base+`rd_idx` (mod 2^ADDR_WIDTH), then `rd_idx` increments.
  - A cycle with `hold_i`=1: `mem_rd_en_o`=0, and `rd_idx` and `mem_addr_o` hold.
  - After the read with `rd_idx`=NUM_PE-1 issues, next state is DRAIN.
- Write pipeline (runs in every state):
  - Register the read strobe and its index for one cycle, to align with `mem_data_i`.
  - On the following edge, register `mem_data_i` into `f_weight_o`, and set `wreg_wr_en_o` to one-hot(index).
  - Read k therefore produces exactly one write of register k.
  - `wreg_wr_en_o` is 0 in any cycle with no pending write; `f_weight_o` holds its last value.
- DRAIN:
  - No reads are issued.
  - Stays until the write for index NUM_PE-1 has been presented, then goes to DONE.
  - `hold_i` is ignored; in-flight data always completes.
- DONE:
  - `done_o`=1 and `busy_o`=0 for 1 cycle.
  - Next state is IDLE.
- `start_i` is ignored in every state except IDLE, including DONE.
- Address wrap: base+k wraps modulo 2^ADDR_WIDTH (e.g. base=1022, ADDR_WIDTH=10 gives addresses 1022, 1023, 0, 1, …).
- Reset mid-operation:
  - Aborts immediately: the next cycle has every output at 0 and the FSM in IDLE.
  - No `done_o` is issued.
  - Data returning from an already-issued read is discarded.
- Weight data passes through unmodified; no sign extension or arithmetic.

## Timing
- Cycle 0 is the edge that samples `start_i`=1, with no holds. Then:
  - cycle 1: `wreg_rst_o`=1, `busy_o`=1.
  - cycles 2..NUM_PE+1: reads 0..NUM_PE-1.
  - cycles 4..NUM_PE+3: `wreg_wr_en_o` bits 0..NUM_PE-1 assert in order.
  - cycle NUM_PE+4: `done_o`=1.
- Total latency from start to done is NUM_PE+4 cycles, plus one cycle per held FETCH cycle.
- Read-to-write latency is fixed at 2 cycles regardless of `hold_i`.
- The write to register k is visible on that register's output the cycle after `wreg_wr_en_o[k]`.
- The earliest next `start_i` is accepted in the cycle after `done_o`.

## Test plan
- Basic load, NUM_PE=4, base=0x010, buffer[0x010..0x013]={5,-3,127,-128}:
  - `wreg_rst_o` at cycle 1.
  - Reads 0x010..0x013 at cycles 2–5.
  - Writes 0001/0010/0100/1000 with 5/-3/127/-128 at cycles 4–7.
  - `done_o` at cycle 8.
- Hold, same setup, `hold_i`=1 during cycles 3–4:
  - Reads at 2, 5, 6, 7.
  - Writes at 4, 7, 8, 9.
  - `done_o` at cycle 10.
- Wrap, ADDR_WIDTH=10, base=1022:
  - `mem_addr_o` sequence 1022, 1023, 0, 1.
  - Writes land in registers 0–3 in that order.
- Start while busy: pulse `start_i` at cycles 3 and at the `done_o` cycle.
  - Both pulses are ignored; exactly one `done_o`.
  - A start in the following cycle begins a new load.
- Reset mid-load: `rst_n_i`=0 at cycle 5.
  - Cycle 6: all outputs 0, no further writes, no `done_o`.
  - A subsequent start performs a full clean load.
- Back-to-back loads with different bases:
  - Each load gives a clear pulse, NUM_PE writes and one `done_o`.
  - Write enables are never active in more than one bit per cycle.
